// File: rtl/stream_rd_pkg.sv
// Shared constants and types for the FIFO drain-side stream reader.
package stream_rd_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int STATS_W    = 16;

   typedef logic [1:0] occ_t;
endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order buffer holding bytes already read from the FIFO but not yet accepted downstream.
module stream_skid_buf
   import stream_rd_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output occ_t              occ
);

   logic [1:0][DATA_W-1:0] mem;
   logic                   head;
   logic                   tail;

   // Tail sits occ slots past head; with occ==2 it aliases head, which is only
   // written when head is popped in the same cycle.
   assign tail = head ^ occ[0];
   assign dout = mem[head];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem  <= '0;
         head <= 1'b0;
         occ  <= '0;
      end else begin
         if (push) mem[tail] <= din;
         if (pop)  head <= ~head;
         unique case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO onto a framed valid/ready byte stream at one byte per cycle.
// Optional pop_count statistics port enabled by defining STREAM_RD_STATS_EN.
module fifo_stream_reader
   import stream_rd_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int PKT_LEN = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               fifo_empty,
   input  logic [DATA_W-1:0]  fifo_data,
   output logic               fifo_rd_en,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
`ifdef STREAM_RD_STATS_EN
   output logic [STATS_W-1:0] pop_count,
`endif
   output logic               out_last
);

   localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(PKT_LEN - 1);

   logic              inflight;
   logic              pop;
   occ_t              occ;
   logic [2:0]        pending;
   logic [BEAT_W-1:0] beat;

   assign pop     = out_valid & out_ready;
   assign pending = {1'b0, occ} + {2'b0, inflight};

   // Bytes held plus bytes in flight must stay within the two buffer slots,
   // counting the slot freed by this cycle's pop.
   assign fifo_rd_en = !rst & enable & !fifo_empty & (pending < (3'd2 + {2'b0, pop}));

   assign out_valid = (occ != 2'd0);
   assign out_last  = out_valid & (beat == BEAT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= 1'b0;
         beat     <= '0;
      end else begin
         inflight <= fifo_rd_en;
         if (pop) beat <= (beat == BEAT_MAX) ? '0 : beat + 1'b1;
      end
   end

   stream_skid_buf #(.DATA_W(DATA_W)) u_buf (
      .clk  (clk),
      .rst  (rst),
      .push (inflight),
      .pop  (pop),
      .din  (fifo_data),
      .dout (out_data),
      .occ  (occ)
   );

`ifdef STREAM_RD_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              pop_count <= '0;
      else if (pop && (pop_count != '1))    pop_count <= pop_count + 1'b1;
   end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed + randomized bench for fifo_stream_reader with an 8-deep registered-output FIFO model
// and a stream scoreboard (order, framing, read capacity). Covers pop_count when STREAM_RD_STATS_EN is defined.
module tb_fifo_stream_reader;
   localparam int DW = 8;
   localparam int PL = 4;

   logic          clk = 1'b0;
   logic          rst, enable, fifo_empty, fifo_rd_en, out_valid, out_ready, out_last;
   logic [DW-1:0] fifo_data, out_data;
`ifdef STREAM_RD_STATS_EN
   logic [15:0]   pop_count;
`endif

   always #5 clk = ~clk;

   fifo_stream_reader #(.DATA_W(DW), .PKT_LEN(PL)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
`ifdef STREAM_RD_STATS_EN
      .pop_count  (pop_count),
`endif
      .out_last   (out_last)
   );

   int n_asrt = 0;
   int n_fail = 0;
   logic [DW-1:0] fq[$];     // FIFO contents
   logic [DW-1:0] expq[$];   // bytes written to the FIFO, not yet seen on the stream
   int acc, outst, feed, rd_seen, pop_seen, lasts;
   bit feed_rand, vld_s, rd_s;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input logic [DW-1:0] b);
      fq.push_back(b);
      expq.push_back(b);
      fifo_empty = 1'b0;
   endtask

   // One clock: check at the falling edge, then advance the FIFO model just after the rising edge.
   task automatic tick();
      logic [DW-1:0] e;
      @(negedge clk);
      vld_s = out_valid;
      rd_s  = fifo_rd_en;
      if (!rst) begin
         if (fifo_rd_en) begin
            chk("rd_while_empty", {31'b0, fifo_empty}, 32'd0);
            rd_seen++;
            outst++;
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) chk("spurious_beat", 32'd1, 32'd0);
            else begin
               e = expq.pop_front();
               chk("data", {24'b0, out_data}, {24'b0, e});
               chk("last", {31'b0, out_last}, {31'b0, (acc % PL) == PL - 1});
            end
            if (out_last) lasts++;
            acc++;
            pop_seen++;
            outst--;
         end
         chk("capacity", {31'b0, outst <= 2}, 32'd1);
      end
      @(posedge clk);
      #1;
      if (rd_s && !rst) fifo_data = fq.pop_front();
      if (feed > 0 && fq.size() < 8 && (!feed_rand || $urandom_range(1, 0) == 1)) begin
         push_byte(DW'($urandom));
         feed--;
      end
      fifo_empty = (fq.size() == 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      fq.delete();
      expq.delete();
      acc = 0; outst = 0; feed = 0; lasts = 0;
      fifo_data  = '0;
      fifo_empty = 1'b1;
      @(negedge clk);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_data",  {24'b0, out_data},  32'd0);
      chk("rst_last",  {31'b0, out_last},  32'd0);
      chk("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((feed > 0 || expq.size() > 0) && n < budget) begin
         tick();
         n++;
      end
      chk(tag, expq.size(), 32'd0);
   endtask

   initial begin
      logic [DW-1:0] first;
      bit exp_v[6] = '{0, 0, 1, 1, 1, 0};
      rst = 1'b1; enable = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
      feed = 0; feed_rand = 0; rd_seen = 0; pop_seen = 0;
      do_reset();

      // First-byte latency and back-to-back delivery
      enable = 1'b1; out_ready = 1'b1;
      tick();
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("latency_vld_%0d", k), {31'b0, vld_s}, {31'b0, exp_v[k]});
      end

      // Back-pressure: exactly two reads, head held stable
      enable = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push_byte(DW'($urandom));
      first = expq[0];
      tick();
      enable = 1'b1; rd_seen = 0;
      repeat (6) tick();
      chk("bp_reads", rd_seen, 32'd2);
      chk("bp_valid", {31'b0, vld_s}, 32'd1);
      chk("bp_data", {24'b0, out_data}, {24'b0, first});
      out_ready = 1'b1;
      drain("bp_drain", 40);
      chk("bp_fifo_count", fq.size(), 32'd0);

      // Random ready, paced feed, packet framing
      do_reset();
      enable = 1'b1; feed = 12; feed_rand = 1;
      for (int n = 0; n < 400 && (feed > 0 || expq.size() > 0); n++) begin
         out_ready = $urandom_range(1, 0);
         tick();
      end
      chk("rand_left", expq.size(), 32'd0);
      chk("rand_lasts", lasts, 32'd3);
      chk("rand_beats", acc, 32'd12);
      feed_rand = 0;

      // Enable dropped right after a read issue
      enable = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_byte(DW'($urandom));
      tick();
      enable = 1'b1;
      tick();
      chk("en_issue", {31'b0, rd_s}, 32'd1);
      enable = 1'b0; rd_seen = 0; pop_seen = 0;
      repeat (5) tick();
      chk("en_off_reads", rd_seen, 32'd0);
      chk("en_off_pops", pop_seen, 32'd1);
      enable = 1'b1;
      drain("en_drain", 40);

      // Reset mid-packet with a read in flight
      feed = 6; pop_seen = 0;
      for (int n = 0; n < 40 && pop_seen < 2; n++) tick();
      chk("mid_inflight", {31'b0, rd_s}, 32'd1);
      do_reset();
      feed = 4;
      drain("post_rst_drain", 40);
      chk("post_rst_lasts", lasts, 32'd1);

`ifdef STREAM_RD_STATS_EN
      do_reset();
      feed = 70000;
      drain("stats_drain", 70100);
      chk("stats_sat", {16'b0, pop_count}, 32'h0000FFFF);
      do_reset();
      chk("stats_rst", {16'b0, pop_count}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drain-side controller for the 8-deep synchronous FIFO. It pops bytes through the FIFO's read port, which has a registered output and one-cycle read latency. It presents the bytes on a valid/ready byte stream with packet framing (`out_last`) and sustains one byte per cycle under back-pressure without ever over-reading. It sits between the FIFO and any downstream stream consumer, such as a serializer or DMA writer.

## Interface
- `DATA_W`, default 8: byte width; must match the FIFO data width.
- `PKT_LEN`, default 4: beats per packet; `out_last` marks every `PKT_LEN`-th accepted beat; legal range 1..256.
- `clk` input 1: clock. All logic is on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `enable` input 1: permits new FIFO reads; deasserting it does not cancel an in-flight read.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_data` input `DATA_W`: FIFO registered read data; valid in the cycle after `fifo_rd_en`.
- `fifo_rd_en` output 1: FIFO pop strobe (combinational).
- `out_valid` output 1: stream data valid.
- `out_ready` input 1: downstream accepts.
- `out_data` output `DATA_W`: stream byte.
- `out_last` output 1: final beat of a packet.

## Operation
- Internal state:
  - `inflight` (1 bit): registered copy of `fifo_rd_en`.
  - `occ` (0..2): entries held in a 2-entry in-order buffer.
  - `beat` (0..`PKT_LEN`-1): packet beat counter.
- `pop` = `out_valid & out_ready`.
- Read issue: `fifo_rd_en = enable & !fifo_empty & (occ + inflight - pop < 2)`.
  - `fifo_rd_en` is never asserted while `fifo_empty` is high.
  - Capacity is never exceeded, so no data is ever dropped.
- Capture: when `inflight` is 1, `fifo_data` is written into the buffer tail at that clock edge.
- Simultaneous pop and capture in one cycle: `occ` is unchanged, the head advances, and ordering is preserved.
- Output signals:
  - `out_valid = (occ != 0)`.
  - `out_data` = buffer head.
  - `out_last = out_valid & (beat == PKT_LEN-1)`.
- `out_data` and `out_last` hold stable while `out_valid & !out_ready`.
- Beat counter: on `pop`, `beat` increments and wraps from `PKT_LEN-1` to 0. A non-accepted cycle does not advance it.
- `enable` low: no new reads. An in-flight byte is still captured and presented, and buffered bytes still drain.
- FIFO empty mid-stream: `out_valid` drops after the buffer drains and `beat` is retained. The packet resumes when data arrives.
- Reset (any time, including mid-packet): `inflight`, `occ` and `beat` clear to 0. A byte in flight is discarded; the FIFO shares `rst`.
- Output values while `rst` is high or after reset:
  - `out_valid` = 0
  - `out_data` = 0
  - `out_last` = 0
  - `fifo_rd_en` = 0 while `rst` is high

## Timing
- `fifo_rd_en` high in cycle n → `fifo_data` valid in cycle n+1 → captured at the end of n+1 → `out_valid` in cycle n+2, provided `occ` was 0.
- First-byte latency from `fifo_empty` falling, with `enable` high: 2 cycles to `out_valid`.
- Steady state with `out_ready` held high: `fifo_rd_en` and `pop` are high every cycle. Throughput is 1 byte/cycle, with `occ` = 1 and `inflight` = 1.
- `out_ready` low: at most 2 further reads are issued. `fifo_rd_en` then stays low until a `pop`.
- `out_ready` rising: a read reissues in the same cycle as the `pop`.

## Configuration
- `STREAM_RD_STATS_EN` defined:
  - Adds output port `pop_count` [15:0]: the count of accepted beats.
  - Increments on `pop` and saturates at 16'hFFFF.
  - Reset value is 0.
- `STREAM_RD_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `stream_rd_pkg`:
  - `DATA_W` default constant.
  - Occupancy typedef `occ_t` (2 bits).
  - Stats width constant `STATS_W` = 16.
- Sub-module `stream_skid_buf`:
  - 2-entry in-order buffer with push, pop, head data, `occ` and asynchronous reset.
  - The top level holds the read-issue logic, `inflight`, the beat counter and the stats counter.

## Test plan
- Reset then write 0x11, 0x22, 0x33 into the FIFO, with `enable`=1 and `out_ready`=1 → the stream yields 0x11, 0x22, 0x33 on consecutive cycles, the first 2 cycles after `fifo_empty` falls. `fifo_rd_en` is never high with `fifo_empty` high.
- FIFO preloaded with 8 bytes, `out_ready`=0 → exactly 2 reads are issued and `out_valid`=1 holds first byte stable. Release `out_ready` → all 8 bytes arrive in order, no loss or duplication, and FIFO `fifo_counter` ends at 0.
- 12 bytes streamed with `PKT_LEN`=4 and random `out_ready` → `out_last` is high on accepted beats 4, 8 and 12 only.
- `enable` dropped in the same cycle as a `fifo_rd_en` → that byte is still delivered, and no further reads occur until `enable`=1.
- `rst` asserted mid-packet with 1 byte in flight → `out_valid`, `out_data` and `out_last` read 0. After release, the next packet's `out_last` falls on beat 4.
- `STREAM_RD_STATS_EN` defined, 70000 beats streamed → `pop_count` = 16'hFFFF, and it is 0 after `rst`.
